im_access_ctrl: RTL and testbench

//  Owns the single port of the instruction memory and shares it between two requesters:
//  the CPU fetch port (single-word reads) and a program loader (burst writes from a base address).

---
 rtl/im_access_ctrl_if.sv | 31 +++
 rtl/im_access_ctrl.sv | 115 +++++++++++
 tb/tb_im_access_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/im_access_ctrl_if.sv
// Requester-side bundle for im_access_ctrl: CPU fetch port plus program-loader burst port.
// The master modport is the requester side and the slave modport is the controller side.
interface im_access_ctrl_if #(
  parameter int DataSize = 32,
  parameter int AddrSize = 10
);
  logic                fetch_req;
  logic [AddrSize-1:0] fetch_addr;
  logic                fetch_gnt;
  logic                fetch_valid;
  logic [DataSize-1:0] fetch_data;

  logic                load_start;
  logic [AddrSize-1:0] load_base;
  logic [AddrSize:0]   load_len;
  logic                load_wvalid;
  logic [DataSize-1:0] load_wdata;
  logic                load_wready;
  logic                load_busy;
  logic                load_done;

  modport master (
    output fetch_req, fetch_addr, load_start, load_base, load_len, load_wvalid, load_wdata,
    input  fetch_gnt, fetch_valid, fetch_data, load_wready, load_busy, load_done
  );

  modport slave (
    input  fetch_req, fetch_addr, load_start, load_base, load_len, load_wvalid, load_wdata,
    output fetch_gnt, fetch_valid, fetch_data, load_wready, load_busy, load_done
  );
endinterface

// File: rtl/im_access_ctrl.sv
// Single-port instruction memory arbiter: CPU fetch reads vs. loader burst writes.
// Round-robin resolves contention while a burst is active; fetch owns the port when idle.
module im_access_ctrl #(
  parameter int DataSize = 32,
  parameter int AddrSize = 10,
  parameter int MemSize  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  im_access_ctrl_if.slave     bus,
  output logic                im_enable_mem,
  output logic                im_enable_fetch,
  output logic                im_enable_write,
  output logic [AddrSize-1:0] im_address,
  output logic [DataSize-1:0] im_din,
  input  logic [DataSize-1:0] im_dout
);

  typedef enum logic {IDLE, LOAD} state_t;
  typedef enum logic {RR_FETCH, RR_LOAD} rr_t;

  state_t              state_q, state_d;
  rr_t                 rr_last_q, rr_last_d;
  logic [AddrSize-1:0] cur_addr_q, cur_addr_d;
  logic [AddrSize:0]   remaining_q, remaining_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic                load_done_q, load_done_d;
  logic                gnt_fetch, gnt_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rr_last_q     <= RR_FETCH;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      fetch_valid_q <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      fetch_valid_q <= fetch_valid_d;
      load_done_q   <= load_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    load_done_d = 1'b0;
    gnt_fetch   = 1'b0;
    gnt_write   = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt_fetch = bus.fetch_req;
        if (bus.load_start) begin
          if (bus.load_len != '0) begin
            state_d     = LOAD;
            cur_addr_d  = bus.load_base;
            remaining_d = bus.load_len;
          end else begin
            load_done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        // Contested cycles go to whoever did not win the previous contest.
        if (bus.fetch_req && bus.load_wvalid) begin
          gnt_write = (rr_last_q == RR_FETCH);
          gnt_fetch = !gnt_write;
          rr_last_d = gnt_write ? RR_LOAD : RR_FETCH;
        end else begin
          gnt_fetch = bus.fetch_req;
          gnt_write = bus.load_wvalid;
        end
        if (gnt_write) begin
          cur_addr_d  = (cur_addr_q == AddrSize'(MemSize - 1)) ? '0
                                                               : cur_addr_q + AddrSize'(1);
          remaining_d = remaining_q - (AddrSize+1)'(1);
          if (remaining_q == (AddrSize+1)'(1)) begin
            state_d     = IDLE;
            load_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    fetch_valid_d = gnt_fetch;

    im_enable_mem   = gnt_fetch | gnt_write;
    im_enable_fetch = gnt_fetch;
    im_enable_write = gnt_write;
    im_address      = '0;
    im_din          = '0;
    if (gnt_fetch) begin
      im_address = bus.fetch_addr;
    end else if (gnt_write) begin
      im_address = cur_addr_q;
      im_din     = bus.load_wdata;
    end
  end

  assign bus.fetch_gnt   = gnt_fetch;
  assign bus.load_wready = gnt_write;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_data  = im_dout;
  assign bus.load_busy   = (state_q == LOAD);
  assign bus.load_done   = load_done_q;

endmodule

// File: tb/tb_im_access_ctrl.sv
// Directed bench for im_access_ctrl with a bus-level reference model and a behavioural memory.
module tb_im_access_ctrl;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MS = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          im_enable_mem, im_enable_fetch, im_enable_write;
  logic [AW-1:0] im_address;
  logic [DW-1:0] im_din;
  logic [DW-1:0] im_dout;

  im_access_ctrl_if #(.DataSize(DW), .AddrSize(AW)) bus ();

  im_access_ctrl #(.DataSize(DW), .AddrSize(AW), .MemSize(MS)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .im_enable_mem(im_enable_mem), .im_enable_fetch(im_enable_fetch),
    .im_enable_write(im_enable_write), .im_address(im_address),
    .im_din(im_din), .im_dout(im_dout)
  );

  always #5 clk = ~clk;

  // Instruction memory with registered read, never reset.
  logic [DW-1:0] mem [MS];
  initial for (int i = 0; i < MS; i++) mem[i] = 32'hA000_0000 + i;
  always @(posedge clk) begin
    if (im_enable_mem && im_enable_write) mem[im_address] <= im_din;
    if (im_enable_mem && im_enable_fetch) im_dout <= mem[im_address];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: golden memory plus a queue of pending burst addresses.
  logic [DW-1:0] gm [MS];
  initial for (int i = 0; i < MS; i++) gm[i] = 32'hA000_0000 + i;
  int      m_q[$];
  bit      m_busy, m_last_fetch, m_valid, m_done;
  logic [DW-1:0] m_data;
  int      n_writes, n_fgnt, n_done, n_busy;

  always @(negedge clk) begin
    bit busy0, contested, ef, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    if (!rst) begin
      m_q.delete();
      m_busy = 0; m_last_fetch = 1; m_valid = 0; m_done = 0;
      check("rst_fetch_gnt", bus.fetch_gnt, 0);
      check("rst_wready", bus.load_wready, 0);
      check("rst_fetch_valid", bus.fetch_valid, 0);
      check("rst_busy", bus.load_busy, 0);
      check("rst_done", bus.load_done, 0);
      check("rst_enables", {im_enable_mem, im_enable_fetch, im_enable_write}, 0);
      check("rst_addr_din", {im_address, im_din}, 0);
    end else begin
      busy0     = m_busy;
      contested = busy0 && bus.fetch_req && bus.load_wvalid;
      if (!busy0) begin
        ef = bus.fetch_req; ew = 0;
      end else if (contested) begin
        ew = m_last_fetch; ef = !ew;
      end else begin
        ef = bus.fetch_req; ew = bus.load_wvalid;
      end
      ea = ef ? bus.fetch_addr : (ew ? AW'(m_q[0]) : '0);
      ed = ew ? bus.load_wdata : '0;

      check("fetch_gnt", bus.fetch_gnt, ef);
      check("load_wready", bus.load_wready, ew);
      check("exclusive", bus.fetch_gnt & bus.load_wready, 0);
      check("im_enables", {im_enable_mem, im_enable_fetch, im_enable_write}, {ef | ew, ef, ew});
      check("im_address", im_address, ea);
      check("im_din", im_din, ed);
      check("fetch_valid", bus.fetch_valid, m_valid);
      if (m_valid) check("fetch_data", bus.fetch_data, m_data);
      check("load_busy", bus.load_busy, m_busy);
      check("load_done", bus.load_done, m_done);

      n_writes += int'(im_enable_write);
      n_fgnt   += int'(bus.fetch_gnt);
      n_done   += int'(bus.load_done);
      n_busy   += int'(bus.load_busy);

      m_valid = ef;
      if (ef) m_data = gm[bus.fetch_addr];
      m_done = 0;
      if (contested) m_last_fetch = ef;
      if (ew) begin
        gm[m_q[0]] = bus.load_wdata;
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_busy = 0; m_done = 1;
        end
      end
      if (!busy0 && bus.load_start) begin
        if (bus.load_len == 0) m_done = 1;
        else begin
          for (int i = 0; i < int'(bus.load_len); i++) m_q.push_back((int'(bus.load_base) + i) % MS);
          m_busy = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_counts();
    n_writes = 0; n_fgnt = 0; n_done = 0; n_busy = 0;
  endtask

  task automatic fetch(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    tick();
    bus.fetch_req = 1; bus.fetch_addr = addr;
    tick();
    bus.fetch_req = 0;
    @(negedge clk);
    check("readback_valid", bus.fetch_valid, 1);
    check("readback_data", bus.fetch_data, exp);
  endtask

  task automatic start_burst(input logic [AW-1:0] base, input logic [AW:0] len);
    tick();
    bus.load_start = 1; bus.load_base = base; bus.load_len = len;
    tick();
    bus.load_start = 0;
  endtask

  task automatic feed(input int n, input logic [DW-1:0] d0, input bit hold_fetch);
    int  i = 0;
    int  budget = 200;
    bit  acc;
    bus.fetch_req   = hold_fetch;
    bus.fetch_addr  = 10'h010;
    bus.load_wvalid = 1; bus.load_wdata = d0;
    while (i < n && budget > 0) begin
      @(negedge clk); acc = bus.load_wready;
      tick();
      budget--;
      if (acc) begin
        i++; bus.load_wdata = d0 + DW'(i);
      end
    end
    if (i < n) check("feed_timeout", 0, 1);
    bus.load_wvalid = 0; bus.fetch_req = 0;
  endtask

  initial begin
    bus.fetch_req = 0; bus.fetch_addr = '0; bus.load_start = 0;
    bus.load_base = '0; bus.load_len = '0; bus.load_wvalid = 0; bus.load_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1;

    // Single fetch after reset.
    fetch(10'h080, 32'hA000_0080);

    // Burst of 4 at 0x80.
    clear_counts();
    start_burst(10'h080, 11'd4);
    feed(4, 32'd1, 0);
    repeat (2) tick();
    check("t2_writes", n_writes, 4);
    check("t2_done_pulses", n_done, 1);
    check("t2_busy_cycles", n_busy, 4);
    for (int i = 0; i < 4; i++) fetch(AW'(10'h080 + i), DW'(i + 1));

    // Burst of 8 contested by a held fetch.
    clear_counts();
    start_burst(10'h100, 11'd8);
    feed(8, 32'h100, 1);
    repeat (2) tick();
    check("t3_writes", n_writes, 8);
    check("t3_fetches_ge4", n_fgnt >= 4, 1);
    check("t3_done_pulses", n_done, 1);
    fetch(10'h107, 32'h107);

    // Wrap across the top of memory.
    start_burst(10'h3FE, 11'd4);
    feed(4, 32'hC0, 0);
    repeat (2) tick();
    fetch(10'h3FE, 32'hC0);
    fetch(10'h3FF, 32'hC1);
    fetch(10'h000, 32'hC2);
    fetch(10'h001, 32'hC3);

    // Zero-length burst, then load_start during busy.
    clear_counts();
    start_burst(10'h055, 11'd0);
    repeat (2) tick();
    check("t5_zero_done", n_done, 1);
    check("t5_zero_writes", n_writes, 0);
    clear_counts();
    start_burst(10'h200, 11'd2);
    start_burst(10'h300, 11'd5);
    feed(2, 32'hD0, 0);
    repeat (2) tick();
    check("t5_writes", n_writes, 2);
    check("t5_done_pulses", n_done, 1);
    fetch(10'h200, 32'hD0);
    fetch(10'h201, 32'hD1);
    fetch(10'h300, 32'hA000_0300);

    // Reset mid-burst, then a clean burst.
    clear_counts();
    start_burst(10'h040, 11'd5);
    feed(2, 32'h70, 0);
    rst = 0;
    @(negedge clk);
    check("t6_busy_after_rst", bus.load_busy, 0);
    check("t6_done_after_rst", bus.load_done, 0);
    tick();
    rst = 1;
    repeat (3) tick();
    check("t6_no_done", n_done, 0);
    start_burst(10'h040, 11'd3);
    feed(3, 32'h55, 0);
    repeat (2) tick();
    check("t6_new_done", n_done, 1);
    fetch(10'h040, 32'h55);
    fetch(10'h042, 32'h57);
    fetch(10'h043, 32'hA000_0043);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
